// File: rtl/nios_dbg_pkg.sv
// nios_dbg_pkg: shared types and jdo field positions for the debug on-chip memory stage
package nios_dbg_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_JRD, ST_JCAP, ST_JWR, ST_CRD} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} op_t;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_LOAD = 35;
  localparam int JDO_CLR_RDY = 36;
  localparam int JDO_CLR_ERR = 37;
endpackage

// File: rtl/nios_dbg_ocimem_ram.sv
// nios_dbg_ocimem_ram: single-port 32-bit synchronous RAM with byte enables and 1-cycle read latency
module nios_dbg_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic [31:0]       q
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    q <= mem[addr];
  end
endmodule

// File: rtl/nios_dbg_ocimem.sv
// nios_dbg_ocimem: JTAG/CPU arbitrated debug RAM with auto-incrementing JTAG address and monitor flags
module nios_dbg_ocimem
  import nios_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  state_t state_q, state_d;
  op_t pend_q, pend_d, first_op, second_op, exec_op, rem1, rem2;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic [31:0] pend_data_q, pend_data_d, cur_data_q, cur_data_d, mon_q, mon_d;
  logic ready_q, ready_d, err_q, err_d;
  logic idle, free, cpu_wr, cpu_rd, done, slot_free, consume_new, drop, addr_load;
  logic [31:0] jdata, ram_q;
  logic unused_jdo;
  assign unused_jdo = ^jdo[JDO_WDATA_LSB-1:0];
  assign jdata = jdo[JDO_WDATA_LSB +: 32];
  always_comb begin
    idle = state_q == ST_IDLE;
    done = state_q == ST_JWR || state_q == ST_JCAP;
    addr_load = take_action_ocimem_a && jdo[JDO_LOAD];
    first_op = take_action_ocimem_b ? OP_WR : take_no_action_ocimem_a ? OP_RD : OP_NONE;
    second_op = (take_action_ocimem_b && take_no_action_ocimem_a) ? OP_RD : OP_NONE;
    consume_new = idle && pend_q == OP_NONE;
    exec_op = idle ? (pend_q != OP_NONE ? pend_q : first_op) : OP_NONE;
    rem1 = consume_new ? second_op : first_op;
    rem2 = consume_new ? OP_NONE : second_op;
    slot_free = idle || pend_q == OP_NONE;
    drop = (rem1 != OP_NONE && !slot_free) || rem2 != OP_NONE;
    free = consume_new && first_op == OP_NONE;
    cpu_wr = !reset && free && avs_write;
    cpu_rd = free && !avs_write && avs_read;
    state_d = idle ? (exec_op == OP_WR ? ST_JWR : exec_op == OP_RD ? ST_JRD : cpu_rd ? ST_CRD : ST_IDLE)
                   : state_q == ST_JRD ? ST_JCAP : ST_IDLE;
    pend_d = (rem1 != OP_NONE && slot_free) ? rem1 : idle ? OP_NONE : pend_q;
    pend_data_d = (rem1 == OP_WR && slot_free) ? jdata : pend_data_q;
    cur_data_d = exec_op == OP_NONE ? cur_data_q : pend_q != OP_NONE ? pend_data_q : jdata;
    jaddr_d = addr_load ? jdo[JDO_ADDR_LSB +: ADDR_W] : done ? jaddr_q + ADDR_W'(1) : jaddr_q;
    mon_d = state_q == ST_JCAP ? ram_q : mon_q;
    ready_d = exec_op != OP_NONE ? 1'b0 : done ? 1'b1
            : (take_action_ocimem_a && jdo[JDO_CLR_RDY]) ? 1'b0 : ready_q;
    err_d = drop || (err_q && !(take_action_ocimem_a && jdo[JDO_CLR_ERR]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q <= OP_NONE;
      jaddr_q <= '0;
      pend_data_q <= '0;
      cur_data_q <= '0;
      mon_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      jaddr_q <= jaddr_d;
      pend_data_q <= pend_data_d;
      cur_data_q <= cur_data_d;
      mon_q <= mon_d;
      ready_q <= ready_d;
      err_q <= err_d;
    end
  end
  nios_dbg_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (!reset && (state_q == ST_JWR || cpu_wr)),
    .addr  ((state_q == ST_JRD || state_q == ST_JWR) ? jaddr_q : avs_address),
    .wdata (state_q == ST_JWR ? cur_data_q : avs_writedata),
    .be    (state_q == ST_JWR ? 4'hf : avs_byteenable),
    .q     (ram_q)
  );
  assign avs_readdata = state_q == ST_CRD ? ram_q : '0;
  assign avs_waitrequest = !((state_q == ST_CRD && avs_read) || cpu_wr);
  assign MonDReg = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;
endmodule
